keypad_scanner: RTL and testbench

// - Input-side counterpart to the multiplexed seven-segment display path.
// - The display driver strobes anodes outward; this block strobes the columns of
//   a 4x4 matrix keypad and reads the rows back.
// - It debounces the keypad, rejects multi-key presses, and delivers one key code
//   per press to the pipelined CPU over a valid/ready handshake.
// - Instantiated in the board top alongside the CPU and display driver.

---
 rtl/keypad_scanner_if.sv | 13 +
 rtl/keypad_scanner.sv | 174 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Key delivery channel from the keypad scanner to the CPU: valid/ready key code plus status levels.
interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_overrun;
    logic       key_pressed;

    modport master (output key_code, output key_valid, output key_overrun,
                    output key_pressed, input key_ready);
    modport slave  (input key_code, input key_valid, input key_overrun,
                    input key_pressed, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchronizer, scan-level debounce,
// multi-key rejection and a single-entry key register with sticky overrun.
module keypad_scanner #(
    parameter int COL_CYCLES     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        row_in,
    output logic [3:0]        col_out,
    keypad_scanner_if.master  kbus
);
    localparam int CW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(COL_CYCLES - 1);
    localparam logic [SW-1:0] DB      = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]    row_s1, row_s2;
    logic [CW-1:0] cnt;
    logic [1:0]    col;
    logic [15:0]   scan_keys, cur_keys;
    logic          sample, scan_end;
    logic [4:0]    n_low;
    logic [3:0]    low_idx;
    logic          none, single;

    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [SW-1:0] stable_q, stable_d, rel_q, rel_d;
    logic          key_event;

    logic [3:0]    code_q;
    logic          valid_q, overrun_q;

    // Rows are asynchronous to clk; idle level is high (pulled up).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign sample   = (cnt == CNT_MAX);
    assign scan_end = sample && (col == 2'd3);
    assign col_out  = ~(4'b0001 << col);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            col       <= 2'd0;
            scan_keys <= '0;
        end else begin
            cnt <= sample ? '0 : cnt + CW'(1);
            if (sample) begin
                col       <= col + 2'd1;
                scan_keys <= cur_keys;
            end
        end
    end

    // Current column's sample merged into the scan image; at scan end this is the full scan.
    always_comb begin
        cur_keys = scan_keys;
        for (int r = 0; r < 4; r++)
            cur_keys[r*4 + int'(col)] = ~row_s2[r];
        n_low   = '0;
        low_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (cur_keys[i]) begin
                n_low   = n_low + 5'd1;
                low_idx = 4'(i);
            end
        end
    end

    assign none   = (n_low == 5'd0);
    assign single = (n_low == 5'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            stable_q <= '0;
            rel_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            rel_q    <= rel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        stable_d  = stable_q;
        rel_d     = rel_q;
        key_event = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (single) begin
                        state_d  = CAND;
                        cand_d   = low_idx;
                        stable_d = SW'(1);
                    end
                end
                CAND: begin
                    if (single && low_idx == cand_q) begin
                        if (stable_q + SW'(1) == DB) begin
                            state_d   = PRESSED;
                            stable_d  = '0;
                            key_event = 1'b1;
                        end else begin
                            stable_d = stable_q + SW'(1);
                        end
                    end else if (single) begin
                        cand_d   = low_idx;
                        stable_d = SW'(1);
                    end else begin
                        state_d  = IDLE;
                        stable_d = '0;
                    end
                end
                PRESSED: begin
                    if (none) begin
                        state_d = REL;
                        rel_d   = SW'(1);
                    end
                end
                REL: begin
                    if (!none) begin
                        state_d = PRESSED;
                        rel_d   = '0;
                    end else if (rel_q + SW'(1) == DB) begin
                        state_d = IDLE;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_q + SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Single-entry holding register; a new key may replace one being consumed this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (key_event) begin
            if (!valid_q || kbus.key_ready) begin
                code_q  <= cand_q;
                valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (valid_q && kbus.key_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign kbus.key_code    = code_q;
    assign kbus.key_valid   = valid_q;
    assign kbus.key_overrun = overrun_q;
    assign kbus.key_pressed = (state_q == PRESSED) || (state_q == REL);
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (COL_CYCLES=4, DEBOUNCE_SCANS=3).
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] keys;
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    keypad_scanner_if kbus ();

    keypad_scanner #(.COL_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .row_in  (row_in),
        .col_out (col_out),
        .kbus    (kbus)
    );

    always #5 clk = ~clk;

    // Key index = row*4 + col; a held key pulls its row low while its column is strobed.
    always_comb begin
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        cyc += n;
        @(negedge clk);
    endtask

    task automatic align();
        while (cyc % 16 != 0) tick(1);
    endtask

    initial begin
        rst = 1'b0;
        keys = '0;
        kbus.key_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_col", col_out, 4'b1110);
        check("rst_valid", {3'b0, kbus.key_valid}, 4'h0);
        check("rst_overrun", {3'b0, kbus.key_overrun}, 4'h0);
        check("rst_pressed", {3'b0, kbus.key_pressed}, 4'h0);
        check("rst_code", kbus.key_code, 4'h0);

        // Clean press of key 9 (row2/col1) held from the start of scan 1
        rst = 1'b1;
        cyc = 0;
        keys = 16'h0200;
        tick(3);  check("col0", col_out, 4'b1110);
        tick(1);  check("col1", col_out, 4'b1101);
        tick(4);  check("col2", col_out, 4'b1011);
        tick(4);  check("col3", col_out, 4'b0111);
        tick(4);  check("col_wrap", col_out, 4'b1110);
        tick(31); check("press_early_valid", {3'b0, kbus.key_valid}, 4'h0);
                  check("press_early_pressed", {3'b0, kbus.key_pressed}, 4'h0);
        tick(1);  check("press_valid", {3'b0, kbus.key_valid}, 4'h1);
                  check("press_code", kbus.key_code, 4'd9);
                  check("press_pressed", {3'b0, kbus.key_pressed}, 4'h1);
        tick(40); check("hold_valid", {3'b0, kbus.key_valid}, 4'h1);
                  check("hold_code", kbus.key_code, 4'd9);
        kbus.key_ready = 1'b1;
        tick(1);
        kbus.key_ready = 1'b0;
        check("consume_valid", {3'b0, kbus.key_valid}, 4'h0);
        tick(48); check("no_repeat", {3'b0, kbus.key_valid}, 4'h0);
        keys = '0;
        tick(100);
        check("release_pressed", {3'b0, kbus.key_pressed}, 4'h0);
        align();

        // Bounce: one scan pressed, one scan released
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? 16'h0080 : 16'h0000;
            tick(16);
            check("bounce_valid", {3'b0, kbus.key_valid}, 4'h0);
        end
        check("bounce_pressed", {3'b0, kbus.key_pressed}, 4'h0);

        // Multi-key rejection, then the survivor is accepted
        keys = 16'h8001;
        tick(64);
        check("multi_valid", {3'b0, kbus.key_valid}, 4'h0);
        check("multi_pressed", {3'b0, kbus.key_pressed}, 4'h0);
        keys = 16'h8000;
        tick(47); check("single15_early", {3'b0, kbus.key_valid}, 4'h0);
        tick(1);  check("single15_valid", {3'b0, kbus.key_valid}, 4'h1);
                  check("single15_code", kbus.key_code, 4'd15);
        kbus.key_ready = 1'b1;
        tick(1);
        kbus.key_ready = 1'b0;
        check("single15_consumed", {3'b0, kbus.key_valid}, 4'h0);
        keys = '0;
        align();
        tick(64);

        // Overrun: key 5 left unconsumed, key 10 dropped
        keys = 16'h0020;
        tick(47); check("k5_early", {3'b0, kbus.key_valid}, 4'h0);
        tick(1);  check("k5_valid", {3'b0, kbus.key_valid}, 4'h1);
                  check("k5_code", kbus.key_code, 4'd5);
        keys = '0;
        tick(64);
        keys = 16'h0400;
        tick(47); check("ovr_before", {3'b0, kbus.key_overrun}, 4'h0);
        tick(1);  check("ovr_set", {3'b0, kbus.key_overrun}, 4'h1);
                  check("ovr_code", kbus.key_code, 4'd5);
                  check("ovr_valid", {3'b0, kbus.key_valid}, 4'h1);
        kbus.key_ready = 1'b1;
        tick(1);
        kbus.key_ready = 1'b0;
        check("ovr_consumed", {3'b0, kbus.key_valid}, 4'h0);
        check("ovr_sticky", {3'b0, kbus.key_overrun}, 4'h1);
        keys = '0;
        align();
        tick(64);

        // Reset in CAND after two stable scans of key 6
        keys = 16'h0040;
        tick(32);
        rst = 1'b0;
        #1;
        check("midrst_col", col_out, 4'b1110);
        check("midrst_valid", {3'b0, kbus.key_valid}, 4'h0);
        check("midrst_overrun", {3'b0, kbus.key_overrun}, 4'h0);
        check("midrst_code", kbus.key_code, 4'h0);
        check("midrst_pressed", {3'b0, kbus.key_pressed}, 4'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        tick(47); check("fresh_early", {3'b0, kbus.key_valid}, 4'h0);
        tick(1);  check("fresh_valid", {3'b0, kbus.key_valid}, 4'h1);
                  check("fresh_code", kbus.key_code, 4'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
